// File: rtl/fb_line_writer.sv
// rtl/fb_line_writer.sv - Bresenham line engine driving the framebuffer BRAM write port
// One pixel write per DRAW cycle; off-screen pixels are walked but not written.
module fb_line_writer #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int CORDW     = 8,
    parameter int WIDTH     = 4,
    localparam int ADDRW    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CORDW-1:0] x0,
    input  logic [CORDW-1:0] y0,
    input  logic [CORDW-1:0] x1,
    input  logic [CORDW-1:0] y1,
    input  logic [WIDTH-1:0] color,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [ADDRW-1:0] addr_write,
    output logic [WIDTH-1:0] data_in
);

    localparam int SW = CORDW + 2;

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    state_t state, next_state;

    logic [CORDW-1:0]     lx0, ly0, lx1, ly1;
    logic [CORDW-1:0]     cx, cy, nx, ny, px, py;
    logic [CORDW-1:0]     abs_x, abs_y;
    logic                 sx_neg, sy_neg;
    logic signed [SW-1:0] dx, dy, err, err_n;
    logic signed [SW:0]   e2, dx_w, dy_w;
    logic                 step_x, step_y, at_end;
    logic [31:0]          addr_full;
    logic                 we_n, busy_n, done_n;
    logic [ADDRW-1:0]     addr_n;

    assign at_end = (cx == lx1) && (cy == ly1);
    assign abs_x  = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
    assign abs_y  = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = INIT;
            INIT:    next_state = DRAW;
            DRAW:    if (at_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Both step decisions look at the pre-update error term.
    always_comb begin
        e2     = {err, 1'b0};
        dx_w   = dx;
        dy_w   = dy;
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        err_n  = err + (step_x ? dy : '0) + (step_y ? dx : '0);
        nx     = step_x ? (sx_neg ? cx - 1'b1 : cx + 1'b1) : cx;
        ny     = step_y ? (sy_neg ? cy - 1'b1 : cy + 1'b1) : cy;
    end

    // Outputs are registered, so they are computed from the pixel presented next cycle.
    always_comb begin
        px        = (state == INIT) ? lx0 : nx;
        py        = (state == INIT) ? ly0 : ny;
        addr_full = {{(32-CORDW){1'b0}}, py} * FB_WIDTH + {{(32-CORDW){1'b0}}, px};
        addr_n    = addr_full[ADDRW-1:0];
        we_n      = ((state == INIT) || (state == DRAW && !at_end))
                    && ({{(32-CORDW){1'b0}}, px} < FB_WIDTH)
                    && ({{(32-CORDW){1'b0}}, py} < FB_HEIGHT);
        busy_n    = (next_state == INIT) || (next_state == DRAW);
        done_n    = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_write <= '0;
            data_in    <= '0;
        end else begin
            we   <= we_n;
            busy <= busy_n;
            done <= done_n;
            if (we_n) addr_write <= addr_n;
            case (state)
                IDLE: if (start) begin
                    lx0     <= x0;
                    ly0     <= y0;
                    lx1     <= x1;
                    ly1     <= y1;
                    data_in <= color;
                end
                INIT: begin
                    sx_neg <= (lx1 < lx0);
                    sy_neg <= (ly1 < ly0);
                    dx     <= {2'b00, abs_x};
                    dy     <= -$signed({2'b00, abs_y});
                    err    <= {2'b00, abs_x} - {2'b00, abs_y};
                    cx     <= lx0;
                    cy     <= ly0;
                end
                DRAW: if (!at_end) begin
                    cx  <= nx;
                    cy  <= ny;
                    err <= err_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_line_writer.sv
// tb/tb_fb_line_writer.sv - directed self-checking bench for fb_line_writer
module tb_fb_line_writer;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  x0, y0, x1, y1;
    logic [3:0]  color;
    logic        busy, done, we;
    logic [14:0] addr_write;
    logic [3:0]  data_in;

    fb_line_writer dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .busy(busy), .done(done), .we(we),
        .addr_write(addr_write), .data_in(data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int wr_off[$], wr_addr[$], wr_data[$], exp_addr[$];
    int done_off, ndone, busy_first, busy_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Offsets j are cycles after the one in which start was presented.
    task automatic run(input logic [7:0] ax0, input logic [7:0] ay0,
                       input logic [7:0] ax1, input logic [7:0] ay1,
                       input logic [3:0] col, input int max_cyc,
                       input int glitch_j, input int rst_j);
        @(negedge clk);
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = col; start = 1'b1;
        wr_off.delete(); wr_addr.delete(); wr_data.delete();
        done_off = -1; ndone = 0; busy_first = -1; busy_last = -1;
        @(negedge clk);
        for (int j = 1; j <= max_cyc; j++) begin
            if (we) begin
                wr_off.push_back(j);
                wr_addr.push_back(int'(addr_write));
                wr_data.push_back(int'(data_in));
            end
            if (busy) begin
                if (busy_first < 0) busy_first = j;
                busy_last = j;
            end
            if (done) begin
                if (done_off < 0) done_off = j;
                ndone++;
            end
            if (rst_j > 0 && j == rst_j + 1) begin
                chk("rst_mid_we", we, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_done", done, 0);
            end
            rst   = (j == rst_j);
            start = (j == glitch_j);
            if (j == glitch_j) begin
                x0 = 8'd50; y0 = 8'd50; x1 = 8'd60; y1 = 8'd60; color = 4'd15;
            end
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int first_off, input int dat);
        chk($sformatf("%s_count", tag), wr_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < wr_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
                chk($sformatf("%s_off%0d", tag, i), wr_off[i], first_off + i);
                chk($sformatf("%s_data%0d", tag, i), wr_data[i], dat);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        x0 = 0; y0 = 0; x1 = 0; y1 = 0; color = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_we", we, 0);
        chk("reset_addr", addr_write, 0);
        chk("reset_data", data_in, 0);
        rst = 1'b0;

        // single point
        run(8'd3, 8'd4, 8'd3, 8'd4, 4'd5, 8, -1, -1);
        exp_addr = '{643};
        check_writes("point", 2, 5);
        chk("point_done", done_off, 3);
        chk("point_ndone", ndone, 1);
        chk("point_busy_first", busy_first, 1);
        chk("point_busy_last", busy_last, 2);

        // horizontal
        run(8'd0, 8'd0, 8'd7, 8'd0, 4'd9, 14, -1, -1);
        exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_writes("horiz", 2, 9);
        chk("horiz_done", done_off, 10);

        // steep
        run(8'd10, 8'd10, 8'd12, 8'd16, 4'd3, 14, -1, -1);
        exp_addr = '{1610, 1770, 1931, 2091, 2251, 2412, 2572};
        check_writes("steep", 2, 3);
        chk("steep_done", done_off, 9);

        // reverse
        run(8'd7, 8'd2, 8'd0, 8'd2, 4'd6, 14, -1, -1);
        exp_addr = '{327, 326, 325, 324, 323, 322, 321, 320};
        check_writes("reverse", 2, 6);
        chk("reverse_done", done_off, 10);

        // right-edge clipping
        run(8'd158, 8'd0, 8'd161, 8'd0, 4'd2, 10, -1, -1);
        exp_addr = '{158, 159};
        check_writes("clip", 2, 2);
        chk("clip_done", done_off, 6);
        chk("clip_busy_last", busy_last, 5);

        // start while busy is ignored
        run(8'd0, 8'd1, 8'd5, 8'd1, 4'd3, 12, 4, -1);
        exp_addr = '{160, 161, 162, 163, 164, 165};
        check_writes("glitch_busy", 2, 3);
        chk("glitch_busy_done", done_off, 8);
        chk("glitch_busy_last", busy_last, 7);

        // start in the done cycle is ignored
        run(8'd0, 8'd1, 8'd5, 8'd1, 4'd4, 12, 8, -1);
        check_writes("glitch_done", 2, 4);
        chk("glitch_done_busy_last", busy_last, 7);
        chk("glitch_done_ndone", ndone, 1);

        // reset mid-line on a 20-pixel line
        run(8'd0, 8'd5, 8'd19, 8'd5, 4'd8, 15, -1, 10);
        exp_addr = '{800, 801, 802, 803, 804, 805, 806, 807, 808};
        check_writes("abort", 2, 8);
        chk("abort_ndone", ndone, 0);
        chk("abort_busy_last", busy_last, 10);

        // fresh line after abort
        run(8'd1, 8'd1, 8'd3, 8'd2, 4'd7, 10, -1, -1);
        exp_addr = '{161, 322, 323};
        check_writes("fresh", 2, 7);
        chk("fresh_done", done_off, 5);
        chk("fresh_ndone", ndone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_line_writer.md
# fb_line_writer

Bresenham line-drawing engine that drives the write port of the framebuffer simple-dual-port BRAM. The display scan-out logic reads that BRAM, and this block is the writer on the other side. It accepts one line command (two endpoints plus a colour) through a start/busy/done handshake. It then emits one pixel write per clock as `we`, `addr_write` and `data_in`, which connect directly to the BRAM write port. Pixels falling outside the framebuffer are clipped: no write is issued for them, but the walk still continues.

## Interface
- `FB_WIDTH`, default 160: framebuffer width in pixels.
- `FB_HEIGHT`, default 120: framebuffer height in pixels.
- `CORDW`, default 8: coordinate width. Coordinates are unsigned, 0..2^CORDW-1.
- `WIDTH`, default 4: pixel data width, matching the BRAM `WIDTH`.
- `ADDRW`, localparam: $clog2(FB_WIDTH*FB_HEIGHT).

Ports:
- `clk` in 1: single clock, shared with the BRAM `clk_write`.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request to draw a line; sampled only in IDLE.
- `x0`, `y0` in CORDW: start point; sampled with `start`.
- `x1`, `y1` in CORDW: end point; sampled with `start`.
- `color` in WIDTH: pixel value; sampled with `start`.
- `busy` out 1: high from INIT through the last DRAW cycle.
- `done` out 1: one-cycle pulse after the last pixel.
- `we` out 1: BRAM write enable.
- `addr_write` out ADDRW: BRAM write address, y*FB_WIDTH+x.
- `data_in` out WIDTH: BRAM write data, equal to the latched `color`.

## Operation
- FSM states are IDLE, INIT, DRAW and DONE.
- IDLE: when `start`=1, latch endpoints and colour, then go to INIT. `start` in any other state is ignored.
- INIT, one cycle:
  - sx = +1 if x1≥x0, else -1; sy likewise.
  - dx = |x1-x0|; dy = -|y1-y0|; err = dx+dy.
  - Set the cursor (x,y) = (x0,y0). Go to DRAW.
- DRAW, one cycle per pixel:
  - Emit the pixel at the current cursor.
  - If the cursor equals (x1,y1), go to DONE.
  - Otherwise compute e2 = 2*err.
  - If e2 ≥ dy: err += dy and x += sx.
  - If e2 ≤ dx: err += dx and y += sy. Both updates use the old err.
- Clipping: if x ≥ FB_WIDTH or y ≥ FB_HEIGHT, `we`=0 for that pixel; `addr_write` is don't-care.
- DONE, one cycle: `done`=1, then return to IDLE.
- Arithmetic:
  - dx, dy and err are signed with CORDW+2 bits; e2 has CORDW+3 bits. No overflow is possible for any CORDW-bit endpoints.
  - Address = y*FB_WIDTH + x, computed from the CORDW-bit cursor and truncated to ADDRW bits. It is only ever used when in range.
- Pixel count P = max(|x1-x0|, |y1-y0|) + 1. Both endpoints are always included. A degenerate line (x0,y0)=(x1,y1) gives P=1.
- Reset (`rst`) in any state:
  - State returns to IDLE; `we`, `busy` and `done` go to 0 at the same edge.
  - No `done` pulse is produced for the aborted line.
  - Writes already issued remain in the BRAM.

## Timing
- Reset values: `busy`=0, `done`=0, `we`=0, `addr_write`=0, `data_in`=0, state IDLE.
- All outputs are registered.
- For `start` sampled at edge N:
  - `busy`=1 from cycle N+1.
  - Pixel k (k=0..P-1) is presented with `we` in cycle N+2+k.
  - `busy`=0 and `done`=1 in cycle N+2+P.
  - The block is back in IDLE at N+3+P and can accept a new `start` then.
- Throughput is one pixel per cycle, with no stall input. The BRAM write port always accepts.
- A `start` asserted in the same cycle as `done` is ignored.
- `data_in` holds the latched colour for the whole line.

## Test plan
- Point (3,4)→(3,4), colour 5:
  - Exactly one write, addr 643, data 5, at N+2.
  - `done` pulses at N+3.
  - `busy` is high for N+1..N+2 only.
- Horizontal line (0,0)→(7,0), colour 9: writes to addr 0..7 in consecutive cycles N+2..N+9, then `done` at N+10.
- Steep line (10,10)→(12,16):
  - Seven writes at (10,10), (10,11), (11,12), (11,13), (11,14), (12,15), (12,16).
  - Addresses 1610, 1770, 1931, 2091, 2251, 2412, 2572.
- Reverse line (7,2)→(0,2): writes descending addr 327..320, one per cycle.
- Clipping, (158,0)→(161,0):
  - Writes only addr 158 and 159.
  - `we`=0 during DRAW cycles 3 and 4.
  - `done` still at N+6.
- Control robustness:
  - Pulse `start` with a different line while `busy`: it is ignored, with no extra writes.
  - Assert `rst` mid-way through a 20-pixel line: `we`, `busy` and `done` are 0 from the next edge, and no `done` pulse occurs.
  - A fresh `start` afterwards draws correctly.
